// File: rtl/instr_pkg.sv
// Shared 16-bit instruction layout, field bundle and packing helper.
// Same bit positions as the instruction decoder.
package instr_pkg;

    localparam int INSTR_W    = 16;
    localparam int CONST_W    = 15;
    localparam int CTOM_BIT   = 15;
    localparam int OP1_BIT    = 12;
    localparam int OP2_LSB    = 10;
    localparam int OPCODE_LSB = 6;
    localparam int JMP_BIT    = 5;
    localparam int LOADD_BIT  = 4;
    localparam int LOADA_BIT  = 3;
    localparam int LOADM_BIT  = 2;

    typedef struct packed {
        logic               ctom;
        logic               jmpifz;
        logic               loada;
        logic               loadd;
        logic               loadm;
        logic               op1;
        logic [1:0]         op2;
        logic [3:0]         opcode;
        logic [CONST_W-1:0] constant;
    } instr_fields_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } fifo_state_t;

    function automatic logic [INSTR_W-1:0] pack_instr(instr_fields_t f);
        logic [INSTR_W-1:0] w;
        w = '0;
        if (f.ctom) begin
            w[CTOM_BIT]          = 1'b1;
            w[CONST_W-1:0]       = f.constant;
        end else begin
            w[OP1_BIT]           = f.op1;
            w[OP2_LSB +: 2]      = f.op2;
            w[OPCODE_LSB +: 4]   = f.opcode;
            w[JMP_BIT]           = f.jmpifz;
            w[LOADD_BIT]         = f.loadd;
            w[LOADA_BIT]         = f.loada;
            w[LOADM_BIT]         = f.loadm;
        end
        return w;
    endfunction

    // Constant form must carry no compute flags; compute form must do something.
    function automatic logic is_illegal(instr_fields_t f);
        logic any_ctl;
        any_ctl = f.jmpifz | f.loada | f.loadd | f.loadm;
        if (f.ctom)
            return any_ctl | f.op1 | (|f.op2) | (|f.opcode);
        return !any_ctl;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input and packed-word output handshakes of instr_encoder.
// master = loader/front end side, slave = encoder side.
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    import instr_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic               cToM;
    logic               jmpIfZ;
    logic               loadA;
    logic               loadD;
    logic               loadM;
    logic               op1;
    logic [1:0]         op2;
    logic [3:0]         opCode;
    logic [CONST_W-1:0] constant;
    logic               clear;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_addr;
    logic               prog_full;
    logic               err;

    modport slave (
        input  in_valid, cToM, jmpIfZ, loadA, loadD, loadM,
        input  op1, op2, opCode, constant, clear, out_ready,
        output in_ready, out_valid, out_instr, out_addr,
        output prog_full, err
    );

    modport master (
        output in_valid, cToM, jmpIfZ, loadA, loadD, loadM,
        output op1, op2, opCode, constant, clear, out_ready,
        input  in_ready, out_valid, out_instr, out_addr,
        input  prog_full, err
    );

endinterface

// File: rtl/instr_fifo2.sv
// Two-entry FIFO holding {instr, addr}; head register drives the output.
// clear and reset both empty it and zero the stored entries.
module instr_fifo2
    import instr_pkg::*;
#(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    fifo_state_t  state;
    logic [W-1:0] head;
    logic [W-1:0] tail;

    assign dout  = head;
    assign full  = (state == TWO);
    assign empty = (state == EMPTY);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        head  <= din;
                        state <= ONE;
                    end
                end
                ONE: begin
                    unique case (1'b1)
                        push && pop: head <= din;
                        push && !pop: begin
                            tail  <= din;
                            state <= TWO;
                        end
                        !push && pop: state <= EMPTY;
                        default: ;
                    endcase
                end
                TWO: begin
                    if (pop) begin
                        head  <= tail;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs control fields into 16-bit words tagged with sequential addresses.
// Define INSTR_ENC_CHECK_EN to enable the sticky illegal-bundle err flag.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    instr_encoder_if.slave  bus
);

    localparam int W = INSTR_W + ADDR_W;

    instr_fields_t      fields;
    logic [INSTR_W-1:0] word;
    logic [ADDR_W-1:0]  addr_q;
    logic               prog_full_q;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [W-1:0]       dout;

    always_comb begin
        fields          = '0;
        fields.ctom     = bus.cToM;
        fields.jmpifz   = bus.jmpIfZ;
        fields.loada    = bus.loadA;
        fields.loadd    = bus.loadD;
        fields.loadm    = bus.loadM;
        fields.op1      = bus.op1;
        fields.op2      = bus.op2;
        fields.opcode   = bus.opCode;
        fields.constant = bus.constant;
    end

    assign word = pack_instr(fields);

    // Ready never depends on out_ready: a full FIFO stalls for a cycle.
    assign bus.in_ready  = !full && !prog_full_q && !bus.clear;
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = !empty && bus.out_ready;
    assign bus.out_valid = !empty;
    assign bus.prog_full = prog_full_q;

    assign bus.out_instr = dout[W-1:ADDR_W];
    assign bus.out_addr  = dout[ADDR_W-1:0];

    instr_fifo2 #(
        .W(W)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(bus.clear),
        .push (push),
        .pop  (pop),
        .din  ({word, addr_q}),
        .dout (dout),
        .full (full),
        .empty(empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || bus.clear) begin
            addr_q      <= '0;
            prog_full_q <= 1'b0;
        end else if (push) begin
            addr_q <= addr_q + 1'b1;
            if (addr_q == '1)
                prog_full_q <= 1'b1;
        end
    end

`ifdef INSTR_ENC_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst_n || bus.clear)
            err_q <= 1'b0;
        else if (push && is_illegal(fields))
            err_q <= 1'b1;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed literals plus a
// queue-based reference model compared every cycle under random traffic.
module tb_instr_encoder;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
`ifdef INSTR_ENC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    bit   chk_en;

    instr_encoder_if #(.ADDR_W(AW)) bus ();

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] q_instr[$];
    int          q_addr[$];
    int          m_addr;
    bit          m_full;
    bit          m_err;

    function automatic logic [15:0] model_word();
        int w;
        if (bus.cToM)
            w = 32768 + int'(bus.constant);
        else
            w = int'(bus.op1) * 4096 + int'(bus.op2) * 1024
              + int'(bus.opCode) * 64 + int'(bus.jmpIfZ) * 32
              + int'(bus.loadD) * 16 + int'(bus.loadA) * 8
              + int'(bus.loadM) * 4;
        return w[15:0];
    endfunction

    function automatic bit model_illegal();
        if (!CHK)
            return 1'b0;
        if (bus.cToM)
            return (bus.jmpIfZ || bus.loadA || bus.loadD || bus.loadM
                    || bus.op1 || bus.op2 != 0 || bus.opCode != 0);
        return !(bus.loadA || bus.loadD || bus.loadM || bus.jmpIfZ);
    endfunction

    always @(posedge clk) begin
        bit acc;
        bit pop;
        if (!rst_n || bus.clear) begin
            q_instr.delete();
            q_addr.delete();
            m_addr = 0;
            m_full = 0;
            m_err  = 0;
        end else begin
            acc = bus.in_valid && q_instr.size() < 2 && !m_full;
            pop = q_instr.size() > 0 && bus.out_ready;
            if (pop) begin
                void'(q_instr.pop_front());
                void'(q_addr.pop_front());
            end
            if (acc) begin
                q_instr.push_back(model_word());
                q_addr.push_back(m_addr);
                if (m_addr == DEPTH - 1)
                    m_full = 1;
                m_err  = m_err || model_illegal();
                m_addr = (m_addr + 1) % DEPTH;
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            bit exp_rdy;
            exp_rdy = q_instr.size() < 2 && !m_full && !bus.clear;
            check("m_out_valid", 32'(bus.out_valid), 32'(q_instr.size() > 0));
            check("m_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            check("m_prog_full", 32'(bus.prog_full), 32'(m_full));
            check("m_err", 32'(bus.err), 32'(m_err));
            if (q_instr.size() > 0) begin
                check("m_out_instr", 32'(bus.out_instr), 32'(q_instr[0]));
                check("m_out_addr", 32'(bus.out_addr), 32'(q_addr[0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_fields();
        bus.cToM     = 0;
        bus.jmpIfZ   = 0;
        bus.loadA    = 0;
        bus.loadD    = 0;
        bus.loadM    = 0;
        bus.op1      = 0;
        bus.op2      = 0;
        bus.opCode   = 0;
        bus.constant = 0;
    endtask

    task automatic set_const(logic [14:0] c);
        zero_fields();
        bus.cToM     = 1;
        bus.constant = c;
    endtask

    task automatic set_comp(logic o1, logic [1:0] o2, logic [3:0] opc,
                            logic j, logic d, logic a, logic m);
        zero_fields();
        bus.op1    = o1;
        bus.op2    = o2;
        bus.opCode = opc;
        bus.jmpIfZ = j;
        bus.loadD  = d;
        bus.loadA  = a;
        bus.loadM  = m;
    endtask

    task automatic do_clear();
        bus.in_valid = 0;
        bus.clear    = 1;
        tick();
        bus.clear    = 0;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        chk_en        = 0;
        rst_n         = 0;
        bus.in_valid  = 0;
        bus.out_ready = 0;
        bus.clear     = 0;
        zero_fields();
        tick();
        tick();
        chk_en = 1;
        rst_n  = 1;

        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_instr", 32'(bus.out_instr), 0);
        check("rst_out_addr", 32'(bus.out_addr), 0);
        check("rst_prog_full", 32'(bus.prog_full), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);

        // Constant form, latency 1
        set_const(15'h7FFF);
        bus.in_valid = 1;
        tick();
        set_const(15'h0000);
        @(negedge clk);
        check("c0_valid", 32'(bus.out_valid), 1);
        check("c0_instr", 32'(bus.out_instr), 32'h FFFF);
        check("c0_addr", 32'(bus.out_addr), 0);
        tick();
        bus.in_valid = 0;
        bus.out_ready = 1;
        @(negedge clk);
        check("c_two_ready", 32'(bus.in_ready), 0);
        check("c0_hold", 32'(bus.out_instr), 32'h FFFF);
        tick();
        @(negedge clk);
        check("c1_instr", 32'(bus.out_instr), 32'h 8000);
        check("c1_addr", 32'(bus.out_addr), 1);
        tick();

        // Compute form at addrs 2,3, which fills the 4-word program
        set_comp(1, 2'b11, 4'hF, 1, 1, 0, 0);
        bus.in_valid = 1;
        tick();
        set_comp(0, 2'b01, 4'h3, 0, 0, 1, 0);
        @(negedge clk);
        check("k0_instr", 32'(bus.out_instr), 32'h 1FF0);
        check("k0_addr", 32'(bus.out_addr), 2);
        tick();
        set_const(15'h0055);
        @(negedge clk);
        check("k1_instr", 32'(bus.out_instr), 32'h 04C8);
        check("k1_addr", 32'(bus.out_addr), 3);
        check("pf_set", 32'(bus.prog_full), 1);
        check("pf_ready", 32'(bus.in_ready), 0);
        tick();
        tick();
        @(negedge clk);
        check("pf_drained", 32'(bus.out_valid), 0);
        check("pf_no_accept", 32'(bus.in_ready), 0);
        bus.clear = 1;
        @(negedge clk);
        check("clr_ready", 32'(bus.in_ready), 0);
        tick();
        bus.clear = 0;
        set_const(15'h1234);
        @(negedge clk);
        check("clr_pf", 32'(bus.prog_full), 0);
        tick();
        bus.in_valid = 0;
        @(negedge clk);
        check("clr_instr", 32'(bus.out_instr), 32'h 9234);
        check("clr_addr", 32'(bus.out_addr), 0);
        tick();
        do_clear();

        // Backpressure: three offered, two taken, order kept
        bus.out_ready = 0;
        bus.in_valid  = 1;
        set_const(15'h0101);
        tick();
        set_const(15'h0202);
        tick();
        set_const(15'h0303);
        tick();
        @(negedge clk);
        check("bp_ready", 32'(bus.in_ready), 0);
        check("bp_hold", 32'(bus.out_instr), 32'h 8101);
        bus.out_ready = 1;
        tick();
        @(negedge clk);
        check("bp_b_instr", 32'(bus.out_instr), 32'h 8202);
        check("bp_b_addr", 32'(bus.out_addr), 1);
        tick();
        bus.in_valid = 0;
        @(negedge clk);
        check("bp_c_instr", 32'(bus.out_instr), 32'h 8303);
        check("bp_c_addr", 32'(bus.out_addr), 2);
        tick();
        @(negedge clk);
        check("bp_empty", 32'(bus.out_valid), 0);
        do_clear();

        // Reset with FIFO in TWO
        bus.out_ready = 0;
        bus.in_valid  = 1;
        set_const(15'h0011);
        tick();
        tick();
        bus.in_valid = 0;
        rst_n = 0;
        tick();
        rst_n = 1;
        @(negedge clk);
        check("mrst_valid", 32'(bus.out_valid), 0);
        check("mrst_addr", 32'(bus.out_addr), 0);
        check("mrst_instr", 32'(bus.out_instr), 0);
        check("mrst_err", 32'(bus.err), 0);

        // clear alongside in_valid: bundle dropped
        bus.in_valid = 1;
        tick();
        bus.clear = 1;
        set_const(15'h0022);
        @(negedge clk);
        check("mclr_ready", 32'(bus.in_ready), 0);
        tick();
        bus.clear    = 0;
        bus.in_valid = 0;
        @(negedge clk);
        check("mclr_valid", 32'(bus.out_valid), 0);

        // Illegal constant bundle
        bus.out_ready = 1;
        set_const(15'h0001);
        bus.loadD    = 1;
        bus.in_valid = 1;
        tick();
        bus.in_valid = 0;
        @(negedge clk);
        check("ill_instr", 32'(bus.out_instr), 32'h 8001);
        check("ill_err", 32'(bus.err), 32'(CHK));
        tick();
        tick();
        @(negedge clk);
        check("ill_sticky", 32'(bus.err), 32'(CHK));
        do_clear();
        @(negedge clk);
        check("ill_cleared", 32'(bus.err), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            tick();
            rst_n         = ($urandom_range(99) != 0);
            bus.clear     = ($urandom_range(39) == 0);
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.out_ready = ($urandom_range(2) != 0);
            bus.cToM      = $urandom_range(1);
            bus.jmpIfZ    = ($urandom_range(3) == 0);
            bus.loadA     = ($urandom_range(3) == 0);
            bus.loadD     = ($urandom_range(3) == 0);
            bus.loadM     = ($urandom_range(3) == 0);
            bus.op1       = ($urandom_range(3) == 0);
            bus.op2       = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b00;
            bus.opCode    = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
            bus.constant  = 15'($urandom);
        end
        tick();
        rst_n        = 1;
        bus.clear    = 0;
        bus.in_valid = 0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Packs CPU control fields into 16-bit instruction words. It is the inverse of the existing instruction decoder.
- Fields are accepted through a valid/ready input. Packed words are buffered in a 2-entry output FIFO.
- Each word leaves through a valid/ready output, tagged with a sequential program address.
- Sits between the program loader/assembler front end and the instruction-memory write port.

Parameters:
- ADDR_W, 8, width of program address counter; program depth = 2**ADDR_W words.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle this cycle.
- cToM  in  1  constant-form select.
- jmpIfZ  in  1  jump-if-zero flag.
- loadA  in  1  load A flag.
- loadD  in  1  load D flag.
- loadM  in  1  load M flag.
- op1  in  1  ALU operand-1 select.
- op2  in  2  ALU operand-2 select.
- opCode  in  4  ALU operation.
- constant  in  15  constant payload.
- clear  in  1  synchronous: flush FIFO, zero address, clear prog_full/err.
- out_valid  out  1  out_instr/out_addr valid.
- out_ready  in  1  downstream accepts word.
- out_instr  out  16  packed instruction.
- out_addr  out  ADDR_W  program address of out_instr.
- prog_full  out  1  last program address has been emitted.
- err  out  1  sticky illegal-bundle flag.

Behaviour:
- Instruction layout, fixed in the package:
  - Constant form: [15]=1, [14:0]=constant.
  - Compute form: [15]=0, [14:13]=0, [12]=op1, [11:10]=op2, [9:6]=opCode, [5]=jmpIfZ, [4]=loadD, [3]=loadA, [2]=loadM, [1:0]=0.
- Form selection:
  - cToM=1: constant form; all compute fields are ignored for packing.
  - cToM=0: compute form; constant is ignored.
- Input acceptance:
  - Accept occurs when in_valid && in_ready.
  - Packing is combinational; the word is written into the FIFO on the accepting edge.
  - out_valid rises the cycle after accept (latency 1).
- FIFO states: EMPTY, ONE, TWO.
  - in_ready = (state != TWO) && !prog_full && !clear.
  - Accept and out handshake in the same cycle: occupancy unchanged, order preserved.
  - In TWO, in_ready=0 even if out_ready=1 that cycle; no combinational ready path from out_ready.
  - out_valid=1 in ONE/TWO. out_instr/out_addr come from the head entry and are stable while out_valid && !out_ready.
- Address counter:
  - An ADDR_W-bit counter is captured per entry at accept; it starts at 0 and increments on each accept.
  - The accept at address 2**ADDR_W-1 sets prog_full. The counter wraps to 0 internally, but no further accepts occur.
  - Words already in the FIFO still drain after prog_full is set.
- clear:
  - Has priority over all handshakes in that cycle.
  - Empties the FIFO, so out_valid=0 next cycle; address=0; prog_full=0; err=0.
- Reset (rst_n=0 at edge): same as clear. All outputs are 0 after reset: out_valid=0, out_instr=0, out_addr=0, prog_full=0, err=0; in_ready=1 from the first cycle after reset.
- Reset or clear mid-stream: buffered words are discarded and are not emitted.

Optional Feature:
- Macro: INSTR_ENC_CHECK_EN.
- With the macro defined, a bundle is illegal on accept if either condition holds:
  - cToM=1 and any of jmpIfZ/loadA/loadD/loadM/op1/op2/opCode is non-zero; or
  - cToM=0 and loadA=loadD=loadM=jmpIfZ=0 (no-effect instruction).
- An illegal bundle sets err (sticky) the cycle after accept. The word is still packed and emitted normally.
- Without the macro: no check logic; err is tied 0.

Decomposition:
- Package instr_pkg holds the shared layout: bit-position/width localparams (CTOM_BIT, OP1_BIT, OP2_LSB, OPCODE_LSB, JMP_BIT, LOADD_BIT, LOADA_BIT, LOADM_BIT, CONST_W=15, INSTR_W=16).
- Package instr_pkg also holds a packed struct instr_fields_t and a function pack_instr(instr_fields_t) returning the 16-bit word. The decoder uses the same positions.
- One sub-module, instr_fifo2: 2-entry FIFO carrying {instr, addr}, with push/pop/clear and the full/empty flags.

Test Plan:
- Constant encoding: after reset, accept cToM=1, constant=0x7FFF, then cToM=1, constant=0x0000 -> out_instr=0xFFFF at addr 0, then 0x8000 at addr 1; first out_valid one cycle after the first accept.
- Compute encoding: accept cToM=0, op1=1, op2=2'b11, opCode=4'hF, jmpIfZ=1, loadD=1, others 0 -> out_instr=0x1FF0. Then accept with op2=2'b01, opCode=4'h3, loadA=1 and all others 0 -> 0x04C8.
- Backpressure: out_ready=0 with 3 bundles offered -> 2 accepted, in_ready=0, out_instr held stable. Raise out_ready -> words emitted in order with addrs 0,1,2 and no loss or duplication.
- Program full (ADDR_W=2): stream 5 bundles with out_ready=1 -> addrs 0..3 emitted; prog_full=1 after the 4th accept; 5th bundle never accepted. clear -> prog_full=0, next word at addr 0.
- Reset and clear mid-stream: with FIFO in TWO, pulse rst_n=0 for one cycle -> out_valid=0, out_addr=0, err=0 next cycle; no stale word emitted. Repeat with clear asserted alongside in_valid -> bundle not accepted.
- INSTR_ENC_CHECK_EN: accept cToM=1, constant=0x0001, loadD=1 -> out_instr=0x8001 and err=1 next cycle, staying set until clear. Without the macro the same stimulus gives err=0.
